// File: rtl/nibble_serial_add_ctrl_if.sv
// nibble_serial_add_ctrl_if: issue-side request/result bundle for the serial nibble adder
interface nibble_serial_add_ctrl_if #(parameter int WIDTH = 16);
  logic start;
  logic sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic c_in;
  logic busy;
  logic done;
  logic [WIDTH-1:0] sum;
  logic c_out;
  logic overflow;
  modport master (output start, sub, a, b, c_in, input busy, done, sum, c_out, overflow);
  modport slave (input start, sub, a, b, c_in, output busy, done, sum, c_out, overflow);
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: WIDTH-bit add/sub time-multiplexed onto one 4-bit ripple slice
module nibble_serial_add_ctrl #(parameter int WIDTH = 16) (
  input logic clk,
  input logic rst,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_r, b_r, acc, acc_n, sum_r;
  logic carry_r, c_out_r, ovf_r, last;
  logic [IW-1:0] idx;
  logic [4:0] slice;
  always_comb begin
    slice = {1'b0, a_r[{idx, 2'b00} +: 4]} + {1'b0, b_r[{idx, 2'b00} +: 4]} + {4'b0, carry_r};
    acc_n = acc;
    acc_n[{idx, 2'b00} +: 4] = slice[3:0];
    last = idx == IW'(NIB - 1);
    state_n = state;
    if (state == IDLE) state_n = bus.start ? RUN : IDLE;
    else if (state == RUN) state_n = last ? DONE : RUN;
    else state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      carry_r <= 1'b0;
      idx <= '0;
      sum_r <= '0;
      c_out_r <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.start) begin
        a_r <= bus.a;
        b_r <= bus.sub ? ~bus.b : bus.b;
        carry_r <= bus.sub | bus.c_in;
        idx <= '0;
      end else if (state == RUN) begin
        acc <= acc_n;
        carry_r <= slice[4];
        idx <= idx + 1'b1;
        // results are published only with the final nibble so partial sums stay hidden
        if (last) begin
          sum_r <= acc_n;
          c_out_r <= slice[4];
          ovf_r <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (acc_n[WIDTH-1] != a_r[WIDTH-1]);
        end
      end
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.sum = sum_r;
  assign bus.c_out = c_out_r;
  assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed scoreboard bench for the serial nibble adder (WIDTH=16)
module tb_nibble_serial_add_ctrl;
  localparam int WIDTH = 16;
  localparam int NIB = WIDTH / 4;
  typedef struct packed {logic [15:0] s; logic c; logic o;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [15:0] held = 16'h0;
  exp_t q[$];
  nibble_serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();
  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // starts an op at the current negedge (IDLE) and follows it to the first IDLE cycle after DONE
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc, input logic ts,
                        input logic [15:0] es, input logic ec, input logic eo, input bit extra);
    exp_t e;
    bus.a = ta; bus.b = tb_v; bus.c_in = tc; bus.sub = ts; bus.start = 1'b1;
    q.push_back('{es, ec, eo});
    for (int k = 1; k <= NIB + 1; k++) begin
      @(negedge clk);
      chk($sformatf("busy_c%0d", k), {31'b0, bus.busy}, 32'd1);
      chk($sformatf("done_c%0d", k), {31'b0, bus.done}, {31'b0, k == NIB + 1});
      if (k <= NIB) chk($sformatf("held_c%0d", k), {16'b0, bus.sum}, {16'b0, held});
      bus.start = extra && (k == 2 || k == 5);
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.c_in = 1'($urandom); bus.sub = 1'($urandom);
    end
    chk("q_nonempty", {31'b0, q.size() != 0}, 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("sum", {16'b0, bus.sum}, {16'b0, e.s});
      chk("c_out", {31'b0, bus.c_out}, {31'b0, e.c});
      chk("overflow", {31'b0, bus.overflow}, {31'b0, e.o});
      held = e.s;
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after", {31'b0, bus.busy}, 32'd0);
    chk("done_after", {31'b0, bus.done}, 32'd0);
  endtask
  initial begin
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_sum", {16'b0, bus.sum}, 32'd0);
    chk("rst_c_out", {31'b0, bus.c_out}, 32'd0);
    chk("rst_ovf", {31'b0, bus.overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b1);
    run_op(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b0);
    run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
    bus.a = 16'h1111; bus.b = 16'h2222; bus.c_in = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("abort_busy_c1", {31'b0, bus.busy}, 32'd1);
    @(negedge clk);
    chk("abort_held_c2", {16'b0, bus.sum}, 32'h2201);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    chk("abort_sum", {16'b0, bus.sum}, 32'd0);
    chk("abort_c_out", {31'b0, bus.c_out}, 32'd0);
    chk("abort_ovf", {31'b0, bus.overflow}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("abort_no_done%0d", k), {31'b0, bus.done}, 32'd0);
      @(negedge clk);
    end
    held = 16'h0;
    rst = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    chk("start_with_rst_dropped", {31'b0, bus.busy}, 32'd0);
    run_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("q_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
